// File: rtl/csync_timing_recovery_if.sv
// Bundles the composite-sync input and the recovered timing outputs.
// Latency: none, wiring only.
// Backpressure: none; the sync stream is free-running and outputs are
// level/pulse signals.
// Ports: csync (active-low sync in); hsync, vsync, field, line_count,
//        line_period, locked, lock_state (recovered timing out).
// master = sync source / timing consumer, slave = timing recovery block.
interface csync_timing_recovery_if #(
    parameter int CNT_W = 12
);
    logic             csync;
    logic             hsync;
    logic             vsync;
    logic             field;
    logic [CNT_W-1:0] line_count;
    logic [CNT_W-1:0] line_period;
    logic             locked;
    logic [1:0]       lock_state;

    modport master (
        output csync,
        input  hsync, vsync, field, line_count, line_period, locked, lock_state
    );

    modport slave (
        input  csync,
        output hsync, vsync, field, line_count, line_period, locked, lock_state
    );
endinterface

// File: rtl/csync_timing_recovery.sv
// Recovers line/field timing (hsync, vsync, field, line count) from a
// synchronised active-low composite sync, with a flywheel and lock FSM.
// Latency: one clock from the first sampled low/high level to the
// registered outputs. Backpressure: none, the stream cannot be stalled.
// Ports: sysClock, nReset (async active low), bus (slave modport).
module csync_timing_recovery #(
    parameter int CNT_W       = 12,
    parameter int H_NOM       = 1024,
    parameter int H_TOL       = 32,
    parameter int HS_WIDTH    = 75,
    parameter int BROAD_MIN   = 256,
    parameter int BROAD_COUNT = 2,
    parameter int LOCK_COUNT  = 8,
    parameter int MISS_MAX    = 4
) (
    input  logic                   sysClock,
    input  logic                   nReset,
    csync_timing_recovery_if.slave bus
);

    // The flywheel point must be reachable before the period counter
    // saturates, otherwise an unlocked channel could never be told apart.
    if (H_NOM + H_TOL >= (2 ** CNT_W) - 1) begin : gParamCheck
        $error("H_NOM + H_TOL must be below the saturated counter value");
    end

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] LO_LIM    = CNT_W'(H_NOM - H_TOL);
    localparam logic [CNT_W-1:0] HI_LIM    = CNT_W'(H_NOM + H_TOL);
    // Reload after an inserted line so the next nominal fall lands on H_NOM.
    localparam logic [CNT_W-1:0] REPHASE   = CNT_W'(H_TOL + 1);
    localparam logic [CNT_W-1:0] Q1_LIM    = CNT_W'(H_NOM / 4);
    localparam logic [CNT_W-1:0] Q3_LIM    = CNT_W'((3 * H_NOM) / 4);
    localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(HS_WIDTH - 1);
    localparam logic [CNT_W-1:0] BROAD_LIM = CNT_W'(BROAD_MIN);
    localparam logic [CNT_W-1:0] BCNT_LIM  = CNT_W'(BROAD_COUNT);
    localparam logic [CNT_W-1:0] LOCK_LIM  = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] MISS_LIM  = CNT_W'(MISS_MAX);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state;
    logic             prevCsync;
    logic [CNT_W-1:0] periodCnt;
    logic [CNT_W-1:0] lowCnt;
    logic [CNT_W-1:0] goodCnt;
    logic [CNT_W-1:0] missCnt;
    logic [CNT_W-1:0] broadCnt;
    logic [CNT_W-1:0] fallPc;     // period count seen at the latest fall
    logic [CNT_W-1:0] fieldPc;    // period count at the first broad fall of a run
    logic [CNT_W-1:0] hsCnt;
    logic             vsDone;
    logic             hsyncReg;
    logic             vsyncReg;
    logic             fieldReg;
    logic             lockedReg;
    logic [CNT_W-1:0] lineCount;
    logic [CNT_W-1:0] linePeriod;

    logic             fall;
    logic             rise;
    logic             inTol;
    logic             isBroad;
    logic             acceptStart;
    logic             insertStart;
    logic             lineStart;
    logic             lockLost;
    logic             vsEvent;
    logic [CNT_W-1:0] broadNext;
    logic [CNT_W-1:0] firstPc;
    logic [CNT_W-1:0] goodInc;
    logic [CNT_W-1:0] missInc;

    assign fall        = prevCsync & ~bus.csync;
    assign rise        = ~prevCsync & bus.csync;
    assign inTol       = (periodCnt >= LO_LIM) && (periodCnt <= HI_LIM);
    assign acceptStart = fall && inTol && (state != SEARCH);
    assign insertStart = (state == LOCKED) && !acceptStart && (periodCnt == HI_LIM);
    assign lineStart   = acceptStart || insertStart;
    assign goodInc     = goodCnt + ONE;
    assign missInc     = missCnt + ONE;
    assign lockLost    = insertStart && (missInc == MISS_LIM);

    assign isBroad     = lowCnt >= BROAD_LIM;
    assign broadNext   = !isBroad ? '0 : ((broadCnt == CNT_MAX) ? broadCnt : broadCnt + ONE);
    assign vsEvent     = rise && isBroad && (broadNext >= BCNT_LIM) && !vsDone;
    // When a single broad pulse is enough, the capture and the vsync coincide.
    assign firstPc     = (broadCnt == '0) ? fallPc : fieldPc;

    always_ff @(posedge sysClock or negedge nReset) begin
        if (!nReset) begin
            state      <= SEARCH;
            prevCsync  <= 1'b1;
            periodCnt  <= '0;
            lowCnt     <= '0;
            goodCnt    <= '0;
            missCnt    <= '0;
            broadCnt   <= '0;
            fallPc     <= '0;
            fieldPc    <= '0;
            hsCnt      <= '0;
            vsDone     <= 1'b0;
            hsyncReg   <= 1'b0;
            vsyncReg   <= 1'b0;
            fieldReg   <= 1'b0;
            lockedReg  <= 1'b0;
            lineCount  <= '0;
            linePeriod <= '0;
        end else begin
            prevCsync <= bus.csync;

            if (fall) begin
                lowCnt <= '0;
                fallPc <= periodCnt;
            end else if (!bus.csync && lowCnt != CNT_MAX) begin
                lowCnt <= lowCnt + ONE;
            end

            if (periodCnt != CNT_MAX) begin
                periodCnt <= periodCnt + ONE;
            end

            case (state)
                SEARCH: begin
                    if (fall) begin
                        periodCnt <= ONE;
                        goodCnt   <= '0;
                        missCnt   <= '0;
                        state     <= ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (acceptStart) begin
                        periodCnt <= ONE;
                        goodCnt   <= goodInc;
                        if (goodInc == LOCK_LIM) begin
                            state     <= LOCKED;
                            lockedReg <= 1'b1;
                            missCnt   <= '0;
                        end
                    end else if (fall && periodCnt > HI_LIM) begin
                        periodCnt <= ONE;
                        goodCnt   <= '0;
                    end else if (periodCnt == CNT_MAX) begin
                        state <= SEARCH;
                    end
                end
                LOCKED: begin
                    if (acceptStart) begin
                        periodCnt <= ONE;
                        missCnt   <= '0;
                    end else if (insertStart) begin
                        periodCnt <= REPHASE;
                        missCnt   <= missInc;
                        if (lockLost) begin
                            state     <= SEARCH;
                            lockedReg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= SEARCH;
                    lockedReg <= 1'b0;
                end
            endcase

            if (acceptStart) begin
                linePeriod <= periodCnt;
            end

            // A new line start while hsync is high restarts the width.
            if (lineStart) begin
                hsyncReg <= 1'b1;
                hsCnt    <= HS_LAST;
            end else if (hsCnt != '0) begin
                hsCnt <= hsCnt - ONE;
            end else begin
                hsyncReg <= 1'b0;
            end

            if (rise) begin
                broadCnt <= broadNext;
                if (!isBroad) begin
                    vsDone <= 1'b0;
                end else if (vsEvent) begin
                    vsDone <= 1'b1;
                end
                if (isBroad && broadCnt == '0) begin
                    fieldPc <= fallPc;
                end
            end

            vsyncReg <= vsEvent;
            if (vsEvent) begin
                fieldReg <= (firstPc > Q1_LIM) && (firstPc < Q3_LIM);
            end

            // vsync wins over a coincident line start.
            if (vsEvent || state == SEARCH || lockLost) begin
                lineCount <= '0;
            end else if (lineStart && lineCount != CNT_MAX) begin
                lineCount <= lineCount + ONE;
            end
        end
    end

    assign bus.hsync       = hsyncReg;
    assign bus.vsync       = vsyncReg;
    assign bus.field       = fieldReg;
    assign bus.line_count  = lineCount;
    assign bus.line_period = linePeriod;
    assign bus.locked      = lockedReg;
    assign bus.lock_state  = state;

endmodule

// File: tb/tb_csync_timing_recovery.sv
// Directed bench for csync_timing_recovery: table of line pulses with
// expected lock/period/count state, then sequences for flywheel loss,
// broad-pulse vsync/field identification and mid-operation reset.
module tb_csync_timing_recovery;
    localparam int CNT_W = 12;

    logic sysClock = 1'b0;
    logic nReset;

    csync_timing_recovery_if #(.CNT_W(CNT_W)) bus ();

    csync_timing_recovery #(
        .CNT_W(CNT_W), .H_NOM(1024), .H_TOL(32), .HS_WIDTH(75),
        .BROAD_MIN(256), .BROAD_COUNT(2), .LOCK_COUNT(8), .MISS_MAX(4)
    ) dut (
        .sysClock(sysClock),
        .nReset(nReset),
        .bus(bus)
    );

    always #5 sysClock = ~sysClock;

    typedef struct {
        int lowLen;
        int period;
        int expState;
        int expLocked;
        int expPeriod;
        int expLines;
        int expRises;
    } vec_t;

    vec_t vecs[15];

    int errors = 0;
    int checks = 0;

    // Observation of the output pulses, sampled away from the active edge.
    int   vsCount = 0;
    int   hsRises = 0;
    int   hsHigh  = 0;
    logic hsPrev  = 1'b0;
    logic fieldAtVs = 1'b0;
    logic [CNT_W-1:0] lcAtVs = '0;

    always @(negedge sysClock) begin
        if (bus.hsync && !hsPrev) hsRises++;
        if (bus.hsync) hsHigh++;
        hsPrev = bus.hsync;
        if (bus.vsync) begin
            vsCount++;
            fieldAtVs = bus.field;
            lcAtVs    = bus.line_count;
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sysClock);
            #1;
        end
    endtask

    // One sync pulse: low for lowLen clocks, next fall period clocks after
    // this fall. lowLen = 0 leaves the line without a pulse.
    task automatic pulse(input int lowLen, input int period);
        if (lowLen > 0) bus.csync = 1'b0;
        tick(lowLen);
        bus.csync = 1'b1;
        tick(period - lowLen);
    endtask

    function automatic vec_t mk(input int lowLen, input int period, input int st, input int lk,
                                input int lp, input int lc, input int rs);
        vec_t v;
        v.lowLen = lowLen; v.period = period; v.expState = st; v.expLocked = lk;
        v.expPeriod = lp; v.expLines = lc; v.expRises = rs;
        return v;
    endfunction

    int vsBase;
    int riseBase;

    initial begin
        // Acquisition on clean lines, then period tracking while locked.
        vecs[0]  = mk(75, 1024, 1, 0, 0,    0,  0);
        vecs[1]  = mk(75, 1024, 1, 0, 1024, 1,  1);
        vecs[2]  = mk(75, 1024, 1, 0, 1024, 2,  2);
        vecs[3]  = mk(75, 1024, 1, 0, 1024, 3,  3);
        vecs[4]  = mk(75, 1024, 1, 0, 1024, 4,  4);
        vecs[5]  = mk(75, 1024, 1, 0, 1024, 5,  5);
        vecs[6]  = mk(75, 1024, 1, 0, 1024, 6,  6);
        vecs[7]  = mk(75, 1024, 1, 0, 1024, 7,  7);
        vecs[8]  = mk(75, 1024, 2, 1, 1024, 8,  8);
        vecs[9]  = mk(75, 1024, 2, 1, 1024, 9,  9);
        vecs[10] = mk(75, 1000, 2, 1, 1024, 10, 10);
        vecs[11] = mk(75, 1050, 2, 1, 1000, 11, 11);
        vecs[12] = mk(75, 990,  2, 1, 1050, 12, 12);
        // 990-clock fall ignored; flywheel inserts, line_period held.
        vecs[13] = mk(75, 1058, 2, 1, 1050, 13, 13);
        vecs[14] = mk(75, 1024, 2, 1, 1024, 14, 14);

        nReset    = 1'b0;
        bus.csync = 1'b1;
        tick(3);
        check("rst_hsync",  32'(bus.hsync), 0);
        check("rst_vsync",  32'(bus.vsync), 0);
        check("rst_field",  32'(bus.field), 0);
        check("rst_lines",  32'(bus.line_count), 0);
        check("rst_period", 32'(bus.line_period), 0);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_state",  32'(bus.lock_state), 0);
        nReset = 1'b1;
        tick(2);

        for (int i = 0; i < 15; i++) begin
            pulse(vecs[i].lowLen, vecs[i].period);
            check($sformatf("v%0d_state", i),  32'(bus.lock_state),  32'(vecs[i].expState));
            check($sformatf("v%0d_locked", i), 32'(bus.locked),      32'(vecs[i].expLocked));
            check($sformatf("v%0d_period", i), 32'(bus.line_period), 32'(vecs[i].expPeriod));
            check($sformatf("v%0d_lines", i),  32'(bus.line_count),  32'(vecs[i].expLines));
            check($sformatf("v%0d_rises", i),  32'(hsRises),         32'(vecs[i].expRises));
        end
        check("hs_width_total", 32'(hsHigh), 32'(14 * 75));

        // One missing pulse: insertion exactly at period count 1056.
        tick(32);
        check("ins_early_hsync", 32'(bus.hsync), 0);
        tick(1);
        check("ins_hsync",  32'(bus.hsync), 1);
        check("ins_locked", 32'(bus.locked), 1);
        check("ins_period", 32'(bus.line_period), 1024);
        tick(991);
        pulse(75, 1024);
        check("ins_resume_lines",  32'(bus.line_count), 16);
        check("ins_resume_locked", 32'(bus.locked), 1);

        // Four missing pulses: lock dropped with the 4th insertion.
        tick(3104);
        check("miss3_state", 32'(bus.lock_state), 2);
        check("miss3_lines", 32'(bus.line_count), 19);
        tick(1);
        check("miss4_state",  32'(bus.lock_state), 0);
        check("miss4_locked", 32'(bus.locked), 0);
        check("miss4_hsync",  32'(bus.hsync), 1);
        check("miss4_lines",  32'(bus.line_count), 0);
        tick(100);

        for (int i = 0; i < 9; i++) pulse(75, 1024);
        check("reacq_state", 32'(bus.lock_state), 2);
        check("reacq_lines", 32'(bus.line_count), 8);

        // Vertical interval, broad pulses aligned to line start.
        vsBase = vsCount; riseBase = hsRises;
        repeat (6) pulse(37, 512);
        repeat (5) pulse(400, 512);
        repeat (5) pulse(37, 512);
        repeat (2) pulse(75, 1024);
        check("f0_vs_count", 32'(vsCount - vsBase), 1);
        check("f0_vs_field", 32'(fieldAtVs), 0);
        check("f0_vs_lines", 32'(lcAtVs), 0);
        check("f0_lines",    32'(bus.line_count), 6);
        check("f0_rises",    32'(hsRises - riseBase), 10);
        check("f0_field",    32'(bus.field), 0);
        check("f0_locked",   32'(bus.locked), 1);

        // Same interval with broad pulses starting half a line late.
        vsBase = vsCount; riseBase = hsRises;
        repeat (5) pulse(37, 512);
        repeat (5) pulse(400, 512);
        repeat (6) pulse(37, 512);
        repeat (2) pulse(75, 1024);
        check("f1_vs_count", 32'(vsCount - vsBase), 1);
        check("f1_vs_field", 32'(fieldAtVs), 1);
        check("f1_vs_lines", 32'(lcAtVs), 0);
        check("f1_lines",    32'(bus.line_count), 6);
        check("f1_rises",    32'(hsRises - riseBase), 10);
        check("f1_field",    32'(bus.field), 1);
        check("f1_locked",   32'(bus.locked), 1);

        // Asynchronous reset in the middle of an hsync pulse.
        bus.csync = 1'b0;
        tick(10);
        check("pre_rst_hsync", 32'(bus.hsync), 1);
        #2;
        nReset = 1'b0;
        #1;
        check("arst_hsync",  32'(bus.hsync), 0);
        check("arst_vsync",  32'(bus.vsync), 0);
        check("arst_field",  32'(bus.field), 0);
        check("arst_lines",  32'(bus.line_count), 0);
        check("arst_period", 32'(bus.line_period), 0);
        check("arst_locked", 32'(bus.locked), 0);
        check("arst_state",  32'(bus.lock_state), 0);
        bus.csync = 1'b1;
        tick(3);
        nReset = 1'b1;
        tick(2);
        pulse(75, 1024);
        check("rerun_acq_state", 32'(bus.lock_state), 1);
        for (int i = 0; i < 9; i++) pulse(75, 1024);
        check("rerun_state",  32'(bus.lock_state), 2);
        check("rerun_locked", 32'(bus.locked), 1);
        check("rerun_period", 32'(bus.line_period), 1024);
        check("rerun_lines",  32'(bus.line_count), 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
